register_file_param: RTL and testbench

- Parametrised successor to the single-cycle 32x32 register file.
- Configurable data width, depth and hard-zero register 0.
- Adds a self-clearing init sequencer (replaces file preload), a ready flag, read enable, single-clock posedge write and optional write-to-read bypass.
- Sits in the CPU datapath between decode (read addresses) and writeback (write port).

---
 rtl/register_file_param_if.sv | 47 ++++
 rtl/register_file_param.sv | 126 ++++++++++++
 tb/tb_register_file_param.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/register_file_param_if.sv
`default_nettype none
// ============================================================================
// Module   : register_file_param_if
// Purpose  : Bus bundle for register_file_param: write port, dual read port,
//            clear request and ready flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   CLR        re-run the clear sequence (honoured only when ready)
//   WE         write enable
//   Write_addr write address          [ADDR_W]
//   Write_data write data             [DATA_W]
//   RE         read enable for both read ports
//   read_regA  port A read address    [ADDR_W]
//   read_regB  port B read address    [ADDR_W]
//   read_dataA port A registered data [DATA_W]
//   read_dataB port B registered data [DATA_W]
//   ready      array initialised and accepting accesses
// Modports: master (datapath side), slave (register file side)
// ============================================================================
interface register_file_param_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              CLR;
  logic              WE;
  logic [ADDR_W-1:0] Write_addr;
  logic [DATA_W-1:0] Write_data;
  logic              RE;
  logic [ADDR_W-1:0] read_regA;
  logic [ADDR_W-1:0] read_regB;
  logic [DATA_W-1:0] read_dataA;
  logic [DATA_W-1:0] read_dataB;
  logic              ready;

  modport master (
    output CLR, WE, Write_addr, Write_data, RE, read_regA, read_regB,
    input  read_dataA, read_dataB, ready
  );

  modport slave (
    input  CLR, WE, Write_addr, Write_data, RE, read_regA, read_regB,
    output read_dataA, read_dataB, ready
  );
endinterface
`default_nettype wire

// File: rtl/register_file_param.sv
`default_nettype none
// ============================================================================
// Module   : register_file_param
// Purpose  : Parametrised CPU register file. One write port, two registered
//            read ports (1-cycle latency), optional hard-zero register 0 and
//            a self-clearing init sequencer that zeroes the array after reset
//            or on a CLR request.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   CLK  clock, all state updates on posedge
//   RST  asynchronous active-high reset
//   bus  register_file_param_if.slave (CLR, WE, Write_addr, Write_data, RE,
//        read_regA/B, read_dataA/B, ready)
// Parameters:
//   DATA_W   register width
//   DEPTH    number of registers (power of two, >= 2)
//   ADDR_W   derived address width, do not override
//   ZERO_REG 1 = register 0 reads 0 and ignores writes
// Build option:
//   RF_BYPASS_EN defined   -> same-cycle write/read forwards the new data
//   RF_BYPASS_EN undefined -> same-cycle read returns the old contents
// ============================================================================
module register_file_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  wire logic CLK,
  input  wire logic RST,
  register_file_param_if.slave bus
);

  localparam logic [0:0] c_st_clear = 1'b0;
  localparam logic [0:0] c_st_ready = 1'b1;
  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(DEPTH - 1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_ready;
  logic [DATA_W-1:0] r_data_a;
  logic [DATA_W-1:0] r_data_b;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_in_ready;
  logic              w_wr_zero;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  assign w_in_ready = (r_state == c_st_ready);
  assign w_wr_zero  = (ZERO_REG != 0) && (bus.Write_addr == '0);
  // A write coinciding with CLR is dropped: the array is about to be wiped.
  assign w_wr_en    = w_in_ready && bus.WE && !bus.CLR && !w_wr_zero;
  assign w_rd_en    = w_in_ready && bus.RE;

  // Next read data for port A. Only accepted user writes are forwarded,
  // never clear-sequence writes (reads are not serviced during CLEAR).
  always_comb begin
    w_rd_a = r_mem[bus.read_regA];
`ifdef RF_BYPASS_EN
    if (w_wr_en && (bus.Write_addr == bus.read_regA)) w_rd_a = bus.Write_data;
`endif
    if ((ZERO_REG != 0) && (bus.read_regA == '0)) w_rd_a = '0;
  end

  always_comb begin
    w_rd_b = r_mem[bus.read_regB];
`ifdef RF_BYPASS_EN
    if (w_wr_en && (bus.Write_addr == bus.read_regB)) w_rd_b = bus.Write_data;
`endif
    if ((ZERO_REG != 0) && (bus.read_regB == '0)) w_rd_b = '0;
  end

  // Control and read registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= c_st_clear;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
      r_data_a  <= '0;
      r_data_b  <= '0;
    end else begin
      case (r_state)
        c_st_clear: begin
          r_data_a  <= '0;
          r_data_b  <= '0;
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == c_last_idx) begin
            r_state   <= c_st_ready;
            r_ready   <= 1'b1;
            r_clr_cnt <= '0;
          end
        end
        default: begin
          if (w_rd_en) begin
            r_data_a <= w_rd_a;
            r_data_b <= w_rd_b;
          end
          if (bus.CLR) begin
            r_state   <= c_st_clear;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
          end
        end
      endcase
    end
  end

  // Array has no reset so it can map onto RAM; the sequencer zeroes it.
  always_ff @(posedge CLK) begin
    if (r_state == c_st_clear) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_en) begin
      r_mem[bus.Write_addr] <= bus.Write_data;
    end
  end

  assign bus.read_dataA = r_data_a;
  assign bus.read_dataB = r_data_b;
  assign bus.ready      = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_register_file_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_param
// Purpose  : Directed self-checking bench for register_file_param. Two DUTs:
//            dut0 default (32x32, ZERO_REG=1), dut1 (64-bit x 16, ZERO_REG=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_param;

`ifdef RF_BYPASS_EN
  localparam bit c_byp = 1'b1;
`else
  localparam bit c_byp = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;

  register_file_param_if #(.DATA_W(32), .DEPTH(32)) bus0 ();
  register_file_param_if #(.DATA_W(64), .DEPTH(16)) bus1 ();

  register_file_param #(.DATA_W(32), .DEPTH(32), .ZERO_REG(1)) dut0 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus0.slave)
  );

  register_file_param #(.DATA_W(64), .DEPTH(16), .ZERO_REG(0)) dut1 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus1.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus0.CLR = 1'b0; bus0.WE = 1'b0; bus0.RE = 1'b0;
    bus1.CLR = 1'b0; bus1.WE = 1'b0; bus1.RE = 1'b0;
  endtask

  // Counts posedges until each DUT raises ready (bounded).
  task automatic wait_ready(input string tag, input int exp0, input int exp1);
    int c0 = 0;
    int c1 = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge CLK);
      if (c0 == 0 && bus0.ready === 1'b1) c0 = i;
      if (c1 == 0 && bus1.ready === 1'b1) c1 = i;
      if (c0 != 0 && c1 != 0) break;
    end
    check({tag, "_cycles0"}, 64'(c0), 64'(exp0));
    check({tag, "_cycles1"}, 64'(c1), 64'(exp1));
  endtask

  initial begin
    idle();
    bus0.Write_addr = '0; bus0.Write_data = '0; bus0.read_regA = '0; bus0.read_regB = '0;
    bus1.Write_addr = '0; bus1.Write_data = '0; bus1.read_regA = '0; bus1.read_regB = '0;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_ready0", 64'(bus0.ready), 64'd0);
    check("rst_dataA0", 64'(bus0.read_dataA), 64'd0);
    check("rst_dataB0", 64'(bus0.read_dataB), 64'd0);
    check("rst_ready1", 64'(bus1.ready), 64'd0);

    // Clear sequence length after release
    RST = 1'b0;
    wait_ready("clear", 32, 16);

    // Every register reads zero after clear
    bus0.RE = 1'b1; bus1.RE = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus0.read_regA = 5'(i);
      bus0.read_regB = 5'(31 - i);
      bus1.read_regA = 4'(i % 16);
      @(negedge CLK);
      check($sformatf("clr_r%0d_A0", i), 64'(bus0.read_dataA), 64'd0);
      check($sformatf("clr_r%0d_B0", 31 - i), 64'(bus0.read_dataB), 64'd0);
      check($sformatf("clr_r%0d_A1", i % 16), bus1.read_dataA, 64'd0);
    end
    idle();

    // Write then read with 1-cycle latency, then hold with RE=0
    bus0.WE = 1'b1; bus0.Write_addr = 5'd5; bus0.Write_data = 32'hDEADBEEF;
    @(negedge CLK);
    bus0.WE = 1'b0; bus0.RE = 1'b1; bus0.read_regA = 5'd5;
    @(negedge CLK);
    check("rd_r5", 64'(bus0.read_dataA), 64'hDEADBEEF);
    bus0.RE = 1'b0; bus0.read_regA = 5'd0;
    @(negedge CLK);
    check("hold_r5", 64'(bus0.read_dataA), 64'hDEADBEEF);

    // Register 0: hard zero on dut0, ordinary on dut1
    bus0.WE = 1'b1; bus0.Write_addr = 5'd0; bus0.Write_data = 32'h12345678;
    bus1.WE = 1'b1; bus1.Write_addr = 4'd0; bus1.Write_data = 64'h12345678;
    @(negedge CLK);
    idle();
    bus0.RE = 1'b1; bus0.read_regA = 5'd0; bus0.read_regB = 5'd0;
    bus1.RE = 1'b1; bus1.read_regA = 4'd0; bus1.read_regB = 4'd0;
    @(negedge CLK);
    check("zero_A0", 64'(bus0.read_dataA), 64'd0);
    check("zero_B0", 64'(bus0.read_dataB), 64'd0);
    check("r0_A1", bus1.read_dataA, 64'h12345678);
    check("r0_B1", bus1.read_dataB, 64'h12345678);
    // Same-cycle write/read of r0 on dut0 must still read zero
    bus0.WE = 1'b1; bus0.Write_data = 32'hCAFEF00D;
    @(negedge CLK);
    check("zero_byp_A0", 64'(bus0.read_dataA), 64'd0);
    idle();

    // Same-cycle hazard on r7
    bus0.WE = 1'b1; bus0.Write_addr = 5'd7; bus0.Write_data = 32'h1;
    bus1.WE = 1'b1; bus1.Write_addr = 4'd7; bus1.Write_data = 64'h1111_0000_0000_0001;
    @(negedge CLK);
    bus0.Write_data = 32'h2; bus1.Write_data = 64'h2222_0000_0000_0002;
    bus0.RE = 1'b1; bus0.read_regA = 5'd7; bus0.read_regB = 5'd7;
    bus1.RE = 1'b1; bus1.read_regA = 4'd7; bus1.read_regB = 4'd7;
    @(negedge CLK);
    check("haz_A0", 64'(bus0.read_dataA), c_byp ? 64'h2 : 64'h1);
    check("haz_B0", 64'(bus0.read_dataB), c_byp ? 64'h2 : 64'h1);
    check("haz_A1", bus1.read_dataA, c_byp ? 64'h2222_0000_0000_0002 : 64'h1111_0000_0000_0001);
    bus0.WE = 1'b0; bus1.WE = 1'b0;
    @(negedge CLK);
    check("haz_next_A0", 64'(bus0.read_dataA), 64'h2);
    check("haz_next_B0", 64'(bus0.read_dataB), 64'h2);
    check("haz_next_B1", bus1.read_dataB, 64'h2222_0000_0000_0002);
    idle();

    // CLR mid-operation: write alongside CLR is dropped, RE still serviced
    bus0.WE = 1'b1; bus0.Write_addr = 5'd3; bus0.Write_data = 32'hAA;
    bus1.WE = 1'b1; bus1.Write_addr = 4'd3; bus1.Write_data = 64'hAA;
    @(negedge CLK);
    bus0.CLR = 1'b1; bus0.Write_addr = 5'd4; bus0.Write_data = 32'h55;
    bus0.RE = 1'b1; bus0.read_regA = 5'd3; bus0.read_regB = 5'd4;
    bus1.CLR = 1'b1; bus1.Write_addr = 4'd4; bus1.Write_data = 64'h55;
    bus1.RE = 1'b1; bus1.read_regA = 4'd3;
    @(negedge CLK);
    check("clr_ready0", 64'(bus0.ready), 64'd0);
    check("clr_ready1", 64'(bus1.ready), 64'd0);
    check("clr_rdA0", 64'(bus0.read_dataA), 64'hAA);
    check("clr_rdA1", bus1.read_dataA, 64'hAA);
    // Hold a write to r3 on dut0 throughout its clear; it must be ignored
    idle();
    bus0.WE = 1'b1; bus0.Write_addr = 5'd3; bus0.Write_data = 32'hFF;
    wait_ready("reclear", 32, 16);
    idle();
    bus0.RE = 1'b1; bus0.read_regA = 5'd3; bus0.read_regB = 5'd4;
    bus1.RE = 1'b1; bus1.read_regA = 4'd3; bus1.read_regB = 4'd4;
    @(negedge CLK);
    check("clr_r3_0", 64'(bus0.read_dataA), 64'd0);
    check("clr_r4_0", 64'(bus0.read_dataB), 64'd0);
    check("clr_r3_1", bus1.read_dataA, 64'd0);
    check("clr_r4_1", bus1.read_dataB, 64'd0);
    idle();

    // Asynchronous reset from READY, then reset again mid-clear
    bus0.WE = 1'b1; bus0.Write_addr = 5'd5; bus0.Write_data = 32'h0BADF00D;
    @(negedge CLK);
    bus0.WE = 1'b0; bus0.RE = 1'b1; bus0.read_regA = 5'd5;
    @(negedge CLK);
    check("pre_rst_r5", 64'(bus0.read_dataA), 64'h0BADF00D);
    idle();
    RST = 1'b1;
    #1;
    check("async_ready0", 64'(bus0.ready), 64'd0);
    check("async_dataA0", 64'(bus0.read_dataA), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    check("midclr_ready0", 64'(bus0.ready), 64'd0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    wait_ready("rst_midclr", 32, 16);
    bus0.RE = 1'b1; bus0.read_regA = 5'd5;
    bus1.RE = 1'b1; bus1.read_regA = 4'd7;
    @(negedge CLK);
    check("post_rst_r5", 64'(bus0.read_dataA), 64'd0);
    check("post_rst_r7_1", bus1.read_dataA, 64'd0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
